// File: rtl/wave_pkg.sv
// Shared encodings for the waveform sequencer: mode codes, controller states
// and default widths.
package wave_pkg;

  localparam int CNT_W_DEFAULT = 5;
  localparam int DIV_W_DEFAULT = 8;

  localparam logic [1:0] MODE_OFF      = 2'b00;
  localparam logic [1:0] MODE_SAW_UP   = 2'b01;
  localparam logic [1:0] MODE_SAW_DOWN = 2'b10;
  localparam logic [1:0] MODE_TRIANGLE = 2'b11;

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] RUN      = 2'b01;
  localparam logic [1:0] STOPPING = 2'b10;

  // Only saw down starts out counting downwards.
  function automatic logic start_up(input logic [1:0] mode);
    return mode != MODE_SAW_DOWN;
  endfunction

endpackage

// File: rtl/rate_prescaler.sv
// Step-rate divider: emits a one-cycle tick every div+1 cycles while run is high.
module rate_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] tick_cnt;

  assign tick = run && (tick_cnt == div);

  // Held at zero while stopped so the first step after a start takes a full period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (clear || !run || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + ONE;
    end
  end

endmodule

// File: rtl/wave_sequencer.sv
// Run-time controller for the waveform counter: paces steps, owns count/direction,
// and swaps configuration only at period boundaries.
module wave_sequencer
  import wave_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [CNT_W-1:0] count,
  output logic             up,
  output logic [1:0]       mode_active,
  output logic             step,
  output logic             period_done,
  output logic             running
);

  localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = 1;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_active;
  logic             pend_valid;
  logic [1:0]       pend_mode;
  logic [DIV_W-1:0] pend_div;

  logic             tick;
  logic             advance;
  logic             wrap;
  logic             boundary;
  logic             load_cfg;
  logic             halt;
  logic [CNT_W-1:0] next_count;
  logic             next_up;

  function automatic logic [CNT_W-1:0] start_count(input logic [1:0] mode);
    return (mode == MODE_SAW_DOWN) ? MAX_CNT : '0;
  endfunction

  assign running   = (state != IDLE);
  assign cfg_ready = !pend_valid;
  assign advance   = running && tick;
  assign boundary  = advance && wrap;
  assign load_cfg  = pend_valid && ((state == IDLE) || boundary);
  assign halt      = boundary && (state == STOPPING) && !enable;

  rate_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (running),
    .clear(load_cfg),
    .div  (div_active),
    .tick (tick)
  );

  // Next count/direction for one step of the active mode; wrap marks a period end.
  always_comb begin
    wrap       = 1'b0;
    next_count = count;
    next_up    = up;
    case (mode_active)
      MODE_SAW_UP: begin
        next_up = 1'b1;
        if (count == MAX_CNT) begin
          wrap       = 1'b1;
          next_count = '0;
        end else begin
          next_count = count + ONE;
        end
      end
      MODE_SAW_DOWN: begin
        next_up = 1'b0;
        if (count == '0) begin
          wrap       = 1'b1;
          next_count = MAX_CNT;
        end else begin
          next_count = count - ONE;
        end
      end
      MODE_TRIANGLE: begin
        if (up && (count == MAX_CNT)) begin
          next_count = MAX_CNT - ONE;
          next_up    = 1'b0;
        end else if (!up && (count == '0)) begin
          next_count = ONE;
          next_up    = 1'b1;
          wrap       = 1'b1;
        end else if (up) begin
          next_count = count + ONE;
        end else begin
          next_count = count - ONE;
        end
      end
      default: begin
        next_count = count;
        next_up    = up;
      end
    endcase
  end

  // A config accepted on a boundary edge lands in pending and waits for the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_mode  <= MODE_OFF;
      pend_div   <= '0;
    end else if (cfg_valid && cfg_ready) begin
      pend_valid <= 1'b1;
      pend_mode  <= cfg_mode;
      pend_div   <= cfg_div;
    end else if (load_cfg) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_active <= MODE_OFF;
      div_active  <= '0;
    end else if (load_cfg) begin
      mode_active <= pend_mode;
      div_active  <= pend_div;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      up          <= 1'b1;
      step        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      step        <= advance;
      period_done <= boundary;
      if (load_cfg) begin
        count <= start_count(pend_mode);
        up    <= start_up(pend_mode);
      end else if (halt) begin
        count <= start_count(mode_active);
        up    <= start_up(mode_active);
      end else if (advance) begin
        count <= next_count;
        up    <= next_up;
      end else if ((state == IDLE) && (mode_active == MODE_OFF)) begin
        count <= '0;
        up    <= 1'b1;
      end
    end
  end

  // Applying an "off" config at a boundary always parks the sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!pend_valid && enable && (mode_active != MODE_OFF)) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (load_cfg && (pend_mode == MODE_OFF)) begin
            state <= IDLE;
          end else if (!enable) begin
            state <= STOPPING;
          end
        end
        STOPPING: begin
          if (load_cfg && (pend_mode == MODE_OFF)) begin
            state <= IDLE;
          end else if (enable) begin
            state <= RUN;
          end else if (boundary) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed scenarios plus random traffic,
// compared cycle by cycle against a waveform-phase reference model.
module tb_wave_sequencer;

  localparam int MAXC = 31;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_div;
  logic [4:0] count;
  logic       up;
  logic [1:0] mode_active;
  logic       step;
  logic       period_done;
  logic       running;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wave_sequencer #(
    .CNT_W(5),
    .DIV_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_div    (cfg_div),
    .count      (count),
    .up         (up),
    .mode_active(mode_active),
    .step       (step),
    .period_done(period_done),
    .running    (running)
  );

  // Reference model: position within the waveform period (m_p) plus pacing state.
  int m_mode, m_div, m_p, m_wait, m_pm, m_pd;
  bit m_run, m_stop, m_pv, m_step, m_pdone;

  function automatic int m_last();
    return (m_mode == 3) ? 2 * MAXC : MAXC;
  endfunction

  function automatic int m_count();
    case (m_mode)
      1: return m_p;
      2: return MAXC - m_p;
      3: return (m_p <= MAXC) ? m_p : 2 * MAXC - m_p;
      default: return 0;
    endcase
  endfunction

  function automatic int m_up();
    if (m_mode == 2) return 0;
    if (m_mode == 3) return (m_p <= MAXC) ? 1 : 0;
    return 1;
  endfunction

  task automatic modelReset();
    m_mode = 0; m_div = 0; m_p = 0; m_wait = 0; m_pm = 0; m_pd = 0;
    m_run = 0; m_stop = 0; m_pv = 0; m_step = 0; m_pdone = 0;
  endtask

  task automatic modelClock(input bit en, input bit cv, input int cm, input int cd);
    bit acc;
    bit halt;
    acc = cv && !m_pv;
    halt = 0;
    m_step = 0;
    m_pdone = 0;
    if (!m_run) begin
      if (m_pv) begin
        m_mode = m_pm; m_div = m_pd; m_p = 0; m_pv = 0;
      end else if (en && m_mode != 0) begin
        m_run = 1; m_wait = 0; m_stop = 0;
      end
    end else begin
      if (m_wait == m_div) begin
        m_wait = 0;
        m_step = 1;
        if (m_p == m_last()) begin
          m_pdone = 1;
          if (m_pv) begin
            m_mode = m_pm; m_div = m_pd; m_pv = 0; m_p = 0;
            if (m_mode == 0) halt = 1;
          end else begin
            m_p = (m_mode == 3) ? 1 : 0;
          end
          if (m_stop && !en) begin
            halt = 1;
            m_p = 0;
          end
        end else begin
          m_p++;
        end
      end else begin
        m_wait++;
      end
      if (halt) m_run = 0;
      else m_stop = !en;
    end
    if (acc) begin
      m_pv = 1; m_pm = cm; m_pd = cd;
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("count", int'(count), m_count());
    checkOutput("up", int'(up), m_up());
    checkOutput("mode_active", int'(mode_active), m_mode);
    checkOutput("step", int'(step), int'(m_step));
    checkOutput("period_done", int'(period_done), int'(m_pdone));
    checkOutput("cfg_ready", int'(cfg_ready), int'(!m_pv));
    checkOutput("running", int'(running), int'(m_run));
  endtask

  task automatic applyStimulus(input bit en, input bit cv, input int cm, input int cd);
    enable    = en;
    cfg_valid = cv;
    cfg_mode  = 2'(cm);
    cfg_div   = 8'(cd);
    @(posedge clk);
    modelClock(en, cv, cm, cd);
    #1;
    compareAll();
  endtask

  task automatic runCycles(input bit en, input int n);
    for (int i = 0; i < n; i++) applyStimulus(en, 0, 0, 0);
  endtask

  // Holds the offer until the model says it was taken; bounded.
  task automatic offerCfg(input bit en, input int cm, input int cd);
    bit taken;
    taken = 0;
    for (int i = 0; i < 600 && !taken; i++) begin
      taken = !m_pv;
      applyStimulus(en, 1, cm, cd);
    end
    if (!taken) checkOutput("offer_timeout", 0, 1);
  endtask

  task automatic runUntil(input bit en, input int mode, input int cnt, input int dir);
    bit hit;
    hit = 0;
    for (int i = 0; i < 800; i++) begin
      hit = (m_mode == mode) && (m_count() == cnt) && (m_up() == dir) && m_run;
      if (hit) break;
      applyStimulus(en, 0, 0, 0);
    end
    if (!hit) checkOutput("wait_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_div = 8'd0;
    modelReset();
    #12;
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_up", int'(up), 1);
    checkOutput("rst_cfg_ready", int'(cfg_ready), 1);
    checkOutput("rst_running", int'(running), 0);
    compareAll();
    reset = 1'b1;

    // Saw up at full rate.
    offerCfg(0, 1, 0);
    runCycles(0, 2);
    runCycles(1, 70);
    // Saw up at div 3, picked up at the next wrap.
    offerCfg(1, 1, 3);
    runCycles(1, 300);
    // Triangle at full rate.
    offerCfg(1, 3, 0);
    runCycles(1, 150);
    // Stop while descending at 5.
    runUntil(1, 3, 5, 0);
    runCycles(0, 30);
    // Restart, then re-enable in the middle of stopping.
    runCycles(1, 20);
    runCycles(0, 5);
    runCycles(1, 40);
    // Switch saw up -> saw down offered at count 10.
    offerCfg(1, 1, 0);
    runUntil(1, 1, 10, 1);
    offerCfg(1, 2, 0);
    runCycles(1, 40);
    // Off mode parks the sequencer at the boundary.
    offerCfg(1, 0, 0);
    runCycles(1, 80);

    // Asynchronous reset mid-run at count 17 with a config pending.
    offerCfg(1, 1, 0);
    runUntil(1, 1, 12, 1);
    applyStimulus(1, 1, 3, 2);
    runUntil(1, 1, 17, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_count", int'(count), 0);
    checkOutput("async_up", int'(up), 1);
    checkOutput("async_mode", int'(mode_active), 0);
    checkOutput("async_cfg_ready", int'(cfg_ready), 1);
    checkOutput("async_running", int'(running), 0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic.
    begin
      bit en_r;
      en_r = 1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 79) == 0) en_r = !en_r;
        applyStimulus(en_r, ($urandom_range(0, 29) == 0), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
